// File: rtl/display_arb_pkg.sv
// Shared types and constants for the display arbiter slice.
package display_arb_pkg;

    localparam int unsigned NUM_REQ     = 3;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned DIGIT_W     = 7;
    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned DIGIT_BUS_W = 28;

    localparam logic [DIGIT_W-1:0] BLANK_DEFAULT = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Four-digit pattern as presented to displaydriver, d3 in the top bits.
    typedef struct packed {
        logic [DIGIT_W-1:0] d3;
        logic [DIGIT_W-1:0] d2;
        logic [DIGIT_W-1:0] d1;
        logic [DIGIT_W-1:0] d0;
    } digits_t;

    // Next requester index in round-robin order, wrapping after the last one.
    function automatic logic [IDX_W-1:0] rr_inc(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx >= IDX_W'(NUM_REQ - 1))
            nxt = '0;
        else
            nxt = idx + IDX_W'(1);
        return nxt;
    endfunction

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/display_rr_picker.sv
// Round-robin picker: first asserted request searching last_grant+1, +2, +3 (mod 3).
module display_rr_picker
    import display_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               valid_c,
    output logic [IDX_W-1:0]   pick_c
);

    logic [IDX_W-1:0] cand_0;
    logic [IDX_W-1:0] cand_1;
    logic [IDX_W-1:0] cand_2;

    // Candidate order; an out-of-range last_grant behaves like the last index.
    always_comb begin
        cand_0 = rr_inc(last_grant);
        cand_1 = rr_inc(cand_0);
        cand_2 = rr_inc(cand_1);
    end

    always_comb begin
        valid_c = |req;
        pick_c  = '0;
        if (req[cand_0])
            pick_c = cand_0;
        else if (req[cand_1])
            pick_c = cand_1;
        else if (req[cand_2])
            pick_c = cand_2;
    end

endmodule

// File: rtl/display_arbiter.sv
// Shares the seven-segment display among three requesters with round-robin,
// min/max on-screen hold and a blank gap between owners.
module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int unsigned        CTR_W      = 25,
    parameter logic [CTR_W-1:0]   MIN_HOLD   = CTR_W'(12_500_000),
    parameter logic [CTR_W-1:0]   MAX_HOLD   = CTR_W'(25_000_000),
    parameter logic [CTR_W-1:0]   GAP_CYCLES = CTR_W'(4),
    parameter logic [DIGIT_W-1:0] BLANK      = BLANK_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [DIGIT_BUS_W-1:0] req_digits_0,
    input  logic [DIGIT_BUS_W-1:0] req_digits_1,
    input  logic [DIGIT_BUS_W-1:0] req_digits_2,
    output logic [NUM_REQ-1:0]     grant,
    output logic [DIGIT_W-1:0]     digit_0,
    output logic [DIGIT_W-1:0]     digit_1,
    output logic [DIGIT_W-1:0]     digit_2,
    output logic [DIGIT_W-1:0]     digit_3,
    output logic                   busy
);

    localparam logic [CTR_W-1:0] MIN_LAST = MIN_HOLD - CTR_W'(1);
    localparam logic [CTR_W-1:0] MAX_LAST = MAX_HOLD - CTR_W'(1);
    localparam logic [CTR_W-1:0] GAP_LAST = GAP_CYCLES - CTR_W'(1);
    localparam digits_t          BLANK_BUS = '{d3: BLANK, d2: BLANK, d1: BLANK, d0: BLANK};

    state_t             state;
    state_t             state_n;
    logic [CTR_W-1:0]   ctr;
    logic [CTR_W-1:0]   ctr_n;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   last_grant_n;
    logic [NUM_REQ-1:0] grant_n;
    digits_t            digits;
    digits_t            digits_n;
    logic               busy_n;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick;
    logic               owner_req;
    logic               others_req;
    logic               release_grant;
    digits_t            owner_digits;
    digits_t            pick_digits;

    function automatic digits_t sel_digits(input logic [IDX_W-1:0] idx,
                                           input digits_t d0,
                                           input digits_t d1,
                                           input digits_t d2);
        digits_t sel;
        case (idx)
            2'd0:    sel = d0;
            2'd1:    sel = d1;
            default: sel = d2;
        endcase
        return sel;
    endfunction

    display_rr_picker u_picker (
        .req        (req),
        .last_grant (last_grant),
        .valid_c    (pick_valid),
        .pick_c     (pick)
    );

    // While in GRANT, last_grant is the current owner.
    always_comb begin
        owner_digits = sel_digits(last_grant, digits_t'(req_digits_0),
                                  digits_t'(req_digits_1), digits_t'(req_digits_2));
        pick_digits  = sel_digits(pick, digits_t'(req_digits_0),
                                  digits_t'(req_digits_1), digits_t'(req_digits_2));
        case (last_grant)
            2'd0:    owner_req = req[0];
            2'd1:    owner_req = req[1];
            default: owner_req = req[2];
        endcase
        others_req    = |(req & ~grant);
        release_grant = (!owner_req && (ctr >= MIN_LAST)) ||
                        ((ctr >= MAX_LAST) && others_req);
    end

    // State register plus the registered outputs computed alongside the next state.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= IDLE;
            ctr        <= '0;
            last_grant <= IDX_W'(2);
            grant      <= '0;
            digits     <= BLANK_BUS;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            ctr        <= ctr_n;
            last_grant <= last_grant_n;
            grant      <= grant_n;
            digits     <= digits_n;
            busy       <= busy_n;
        end
    end

    always_comb begin
        state_n      = state;
        ctr_n        = ctr;
        last_grant_n = last_grant;
        grant_n      = grant;
        digits_n     = digits;

        case (state)
            IDLE: begin
                grant_n  = '0;
                digits_n = BLANK_BUS;
                ctr_n    = '0;
                if (pick_valid) begin
                    state_n      = GRANT;
                    grant_n      = idx_to_onehot(pick);
                    last_grant_n = pick;
                    digits_n     = pick_digits;
                end
            end
            GRANT: begin
                ctr_n = (ctr >= MAX_HOLD) ? ctr : ctr + CTR_W'(1);
                if (owner_req)
                    digits_n = owner_digits;
                if (release_grant) begin
                    state_n  = GAP;
                    grant_n  = '0;
                    digits_n = BLANK_BUS;
                    ctr_n    = '0;
                end
            end
            GAP: begin
                grant_n  = '0;
                digits_n = BLANK_BUS;
                if (ctr >= GAP_LAST) begin
                    state_n = IDLE;
                    ctr_n   = '0;
                end else begin
                    ctr_n = ctr + CTR_W'(1);
                end
            end
            default: begin
                state_n  = IDLE;
                grant_n  = '0;
                digits_n = BLANK_BUS;
                ctr_n    = '0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    assign digit_0 = digits.d0;
    assign digit_1 = digits.d1;
    assign digit_2 = digits.d2;
    assign digit_3 = digits.d3;

endmodule
